// File: rtl/spi_regfile_pkg.sv
//------------------------------------------------------------------------------
// Module   : spi_regfile_pkg
// Purpose  : Shared types and constants for the SPI register file.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spi_regfile_pkg;

    localparam int CMD_LEN = 8;
    localparam int ADDR_W  = 7;
    localparam int RW_BIT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    // Auto-increment with wrap back to register 0 after the last register.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a,
                                                   input int unsigned       num);
        return (a == ADDR_W'(num - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_regfile_if.sv
//------------------------------------------------------------------------------
// Module   : spi_regfile_if
// Purpose  : SPI bus bundle (SCLK/MOSI/MISO/CS) with master and slave views.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface spi_regfile_if;

    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;
    logic spi_cs;

    modport master (
        output spi_sclk,
        output spi_mosi,
        output spi_cs,
        input  spi_miso
    );

    modport slave (
        input  spi_sclk,
        input  spi_mosi,
        input  spi_cs,
        output spi_miso
    );

endinterface

`default_nettype wire

// File: rtl/spi_sync.sv
//------------------------------------------------------------------------------
// Module   : spi_sync
// Purpose  : Two-flop synchroniser with rising/falling edge detect.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  wire  clk_i,
    input  wire  rst_ni,
    input  wire  i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_regfile.sv
//------------------------------------------------------------------------------
// Module   : spi_regfile
// Purpose  : SPI mode-0 slave giving burst read/write access to a register file.
//            Read-back path enabled by defining SPI_REGFILE_READBACK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int NUM_REGISTERS = 8,
    parameter int LEN_REGISTER  = 8,
    parameter logic [NUM_REGISTERS*LEN_REGISTER-1:0] RESET_VALUES = '0
) (
    input  wire                                     clk_i,
    input  wire                                     rst_ni,
    input  wire                                     enable,
    input  wire                                     spi_sclk,
    input  wire                                     spi_mosi,
    output logic                                    spi_miso,
    input  wire                                     spi_cs,
    output logic [NUM_REGISTERS*LEN_REGISTER-1:0]   regs_o,
    output logic [NUM_REGISTERS-1:0]                wr_strobe_o,
    output logic                                    busy_o
);

    localparam int IDX_W   = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
    localparam int CNT_W   = 6;
    localparam int SHIFT_W = (LEN_REGISTER > CMD_LEN) ? LEN_REGISTER : CMD_LEN;

    state_t                    r_state;
    logic [LEN_REGISTER-1:0]   r_regs [NUM_REGISTERS];
    logic [SHIFT_W-1:0]        r_shift;
    logic [CNT_W-1:0]          r_bit_cnt;
    logic [ADDR_W-1:0]         r_addr;
    logic                      r_oor;
    logic                      r_ignore;
    logic [NUM_REGISTERS-1:0]  r_wr_strobe;
    logic                      r_mosi_meta;
    logic                      r_mosi_sync;

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;

    spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_async (spi_sclk),
        .o_level (w_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_async (spi_cs),
        .o_level (w_cs_lvl),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    logic [CMD_LEN-1:0]      w_cmd;
    logic [LEN_REGISTER-1:0] w_word;
    logic                    w_cmd_oor;
    logic [ADDR_W-1:0]       w_addr_next;
    logic [IDX_W-1:0]        w_idx;

    assign w_cmd       = {r_shift[CMD_LEN-2:0], r_mosi_sync};
    assign w_word      = {r_shift[LEN_REGISTER-2:0], r_mosi_sync};
    assign w_cmd_oor   = ({1'b0, w_cmd[ADDR_W-1:0]} >= (ADDR_W+1)'(NUM_REGISTERS));
    assign w_addr_next = addr_inc(r_addr, NUM_REGISTERS);
    assign w_idx       = r_addr[IDX_W-1:0];

`ifdef SPI_REGFILE_READBACK_EN
    logic                    r_miso;
    logic [LEN_REGISTER-1:0] r_rshift;
    logic [IDX_W-1:0]        w_cmd_idx;
    logic [IDX_W-1:0]        w_next_idx;

    assign w_cmd_idx  = w_cmd[IDX_W-1:0];
    assign w_next_idx = w_addr_next[IDX_W-1:0];
    assign spi_miso   = r_miso;
`else
    assign spi_miso   = 1'b0;
`endif

    wire w_unused_sync = w_sclk_lvl ^ w_cs_rise ^ w_sclk_fall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_addr      <= '0;
            r_oor       <= 1'b0;
            r_ignore    <= 1'b0;
            r_wr_strobe <= '0;
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                r_regs[i] <= RESET_VALUES[i*LEN_REGISTER +: LEN_REGISTER];
            end
`ifdef SPI_REGFILE_READBACK_EN
            r_miso      <= 1'b0;
            r_rshift    <= '0;
`endif
        end else begin
            r_wr_strobe <= '0;
            // Abort drops any partially shifted byte/word; nothing is written.
            if (!enable || (r_state != ST_IDLE && w_cs_lvl)) begin
                r_state   <= ST_IDLE;
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_oor     <= 1'b0;
                r_ignore  <= 1'b0;
`ifdef SPI_REGFILE_READBACK_EN
                r_miso    <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= ST_CMD;
                            r_shift   <= '0;
                            r_bit_cnt <= '0;
                            r_ignore  <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise && !r_ignore) begin
                            r_shift <= {r_shift[SHIFT_W-2:0], r_mosi_sync};
                            if (r_bit_cnt == CNT_W'(CMD_LEN - 1)) begin
                                r_bit_cnt <= '0;
                                r_addr    <= w_cmd[ADDR_W-1:0];
                                r_oor     <= w_cmd_oor;
                                if (w_cmd[RW_BIT]) begin
`ifdef SPI_REGFILE_READBACK_EN
                                    r_state  <= ST_RDATA;
                                    r_rshift <= w_cmd_oor ? '0 : r_regs[w_cmd_idx];
                                    r_miso   <= w_cmd_oor ? 1'b0
                                                          : r_regs[w_cmd_idx][LEN_REGISTER-1];
`else
                                    r_ignore <= 1'b1;
`endif
                                end else begin
                                    r_state <= ST_WDATA;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_sclk_rise) begin
                            r_shift <= {r_shift[SHIFT_W-2:0], r_mosi_sync};
                            if (r_bit_cnt == CNT_W'(LEN_REGISTER - 1)) begin
                                r_bit_cnt <= '0;
                                if (!r_oor) begin
                                    r_regs[w_idx]      <= w_word;
                                    r_wr_strobe[w_idx] <= 1'b1;
                                    r_addr             <= w_addr_next;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
`ifdef SPI_REGFILE_READBACK_EN
                    ST_RDATA: begin
                        // The first falling edge re-presents the MSB already on MISO.
                        if (w_sclk_fall) begin
                            r_miso   <= r_rshift[LEN_REGISTER-1];
                            r_rshift <= {r_rshift[LEN_REGISTER-2:0], 1'b0};
                        end
                        if (w_sclk_rise) begin
                            if (r_bit_cnt == CNT_W'(LEN_REGISTER - 1)) begin
                                r_bit_cnt <= '0;
                                if (!r_oor) begin
                                    r_addr   <= w_addr_next;
                                    r_rshift <= r_regs[w_next_idx];
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
`endif
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGISTERS; gi++) begin : g_flat
        assign regs_o[gi*LEN_REGISTER +: LEN_REGISTER] = r_regs[gi];
    end

    assign wr_strobe_o = r_wr_strobe;
    assign busy_o      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_regfile.sv
//------------------------------------------------------------------------------
// Module   : tb_spi_regfile
// Purpose  : Directed, table-driven bench for spi_regfile (both build variants).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_regfile;

    localparam logic [63:0] INIT = 64'h17161514131211A5;

`ifdef SPI_REGFILE_READBACK_EN
    localparam logic [23:0] RX_R2 = 24'h003C13;
    localparam logic [23:0] RX_R7 = 24'h022233;
`else
    localparam logic [23:0] RX_R2 = 24'h000000;
    localparam logic [23:0] RX_R7 = 24'h000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [63:0] regs;
    logic [7:0]  strobe;
    logic        busy;
    int          checks = 0;
    int          failures = 0;
    int          pcnt [8];
    int          snap [8];

    spi_regfile_if intf ();

    spi_regfile #(
        .NUM_REGISTERS (8),
        .LEN_REGISTER  (8),
        .RESET_VALUES  (INIT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable      (enable),
        .spi_sclk    (intf.spi_sclk),
        .spi_mosi    (intf.spi_mosi),
        .spi_miso    (intf.spi_miso),
        .spi_cs      (intf.spi_cs),
        .regs_o      (regs),
        .wr_strobe_o (strobe),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) if (strobe[i]) pcnt[i] = pcnt[i] + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        int          nw;
        logic [23:0] data;
        logic [63:0] exp_regs;
        logic [7:0]  exp_mask;
        int          exp_cnt;
        logic [23:0] exp_rx;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic take_snap();
        for (int i = 0; i < 8; i++) snap[i] = pcnt[i];
    endtask

    task automatic strobe_delta(output logic [7:0] mask, output int cnt);
        mask = '0;
        cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            if (pcnt[i] != snap[i]) mask[i] = 1'b1;
            cnt += pcnt[i] - snap[i];
        end
    endtask

    // One SCLK period: MOSI set while low, MISO sampled just before the rise.
    task automatic spi_bit(input logic b, output logic m);
        intf.spi_mosi = b;
        repeat (4) @(negedge clk);
        m = intf.spi_miso;
        intf.spi_sclk = 1'b1;
        repeat (4) @(negedge clk);
        intf.spi_sclk = 1'b0;
    endtask

    task automatic cs_low();
        intf.spi_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        intf.spi_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic m;
        for (int i = 7; i >= 0; i--) spi_bit(v[i], m);
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input int nw, input logic [23:0] data,
                            output logic [23:0] rx);
        logic m;
        rx = '0;
        cs_low();
        send_byte(cmd);
        for (int w = 0; w < nw; w++) begin
            for (int i = 7; i >= 0; i--) begin
                spi_bit(data[(2-w)*8 + i], m);
                rx = {rx[22:0], m};
            end
        end
        cs_high();
    endtask

    initial begin
        logic [23:0] rx;
        logic [7:0]  mask;
        int          cnt;
        logic        m;

        vt[0] = '{"wr_r2",      8'h02, 1, 24'h3C0000, 64'h17161514133C11A5, 8'h04, 1, 24'h0};
        vt[1] = '{"burst_wrap", 8'h07, 3, 24'h112233, 64'h11161514133C3322, 8'h83, 3, 24'h0};
        vt[2] = '{"rd_r2",      8'h82, 2, 24'hFFFF00, 64'h11161514133C3322, 8'h00, 0, RX_R2};
        vt[3] = '{"wr_oor",     8'h10, 1, 24'hFF0000, 64'h11161514133C3322, 8'h00, 0, 24'h0};
        vt[4] = '{"wr_r5",      8'h05, 1, 24'h5A0000, 64'h11165A14133C3322, 8'h20, 1, 24'h0};
        vt[5] = '{"burst_r6",   8'h06, 2, 24'h010200, 64'h02015A14133C3322, 8'hC0, 2, 24'h0};
        vt[6] = '{"rd_r7_wrap", 8'h87, 3, 24'hFFFFFF, 64'h02015A14133C3322, 8'h00, 0, RX_R7};
        vt[7] = '{"rd_oor",     8'hC0, 1, 24'hFF0000, 64'h02015A14133C3322, 8'h00, 0, 24'h0};

        rst_n = 1'b0;
        enable = 1'b1;
        intf.spi_sclk = 1'b0;
        intf.spi_mosi = 1'b0;
        intf.spi_cs   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_regs",   regs, INIT);
        check("reset_miso",   64'(intf.spi_miso), 64'h0);
        check("reset_busy",   64'(busy), 64'h0);
        check("reset_strobe", 64'(strobe), 64'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            take_snap();
            spi_xfer(vt[v].cmd, vt[v].nw, vt[v].data, rx);
            strobe_delta(mask, cnt);
            check({vt[v].name, "_regs"},   regs, vt[v].exp_regs);
            check({vt[v].name, "_mask"},   64'(mask), 64'(vt[v].exp_mask));
            check({vt[v].name, "_pulses"}, 64'(cnt), 64'(vt[v].exp_cnt));
            check({vt[v].name, "_miso"},   64'(rx), 64'(vt[v].exp_rx));
            check({vt[v].name, "_busy"},   64'(busy), 64'h0);
        end

        // Write latency: reg3 visible 4 clk cycles after the last data rise.
        take_snap();
        cs_low();
        check("busy_active", 64'(busy), 64'h1);
        send_byte(8'h03);
        send_byte(8'hC3);
        check("latency_r3", 64'(regs[31:24]), 64'hC3);
        cs_high();
        strobe_delta(mask, cnt);
        check("latency_mask", 64'(mask), 64'h08);

        // Partial word then cs release: no write, next transaction still decodes.
        take_snap();
        cs_low();
        send_byte(8'h04);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
        cs_high();
        strobe_delta(mask, cnt);
        check("abort_regs",   regs, 64'h02015A14C33C3322);
        check("abort_pulses", 64'(cnt), 64'h0);
        check("abort_busy",   64'(busy), 64'h0);
        spi_xfer(8'h04, 1, 24'h770000, rx);
        check("after_abort_regs", regs, 64'h02015A77C33C3322);

        // Enable dropped mid-word: forced idle, no write.
        take_snap();
        cs_low();
        send_byte(8'h01);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check("enable_low_busy", 64'(busy), 64'h0);
        for (int i = 0; i < 5; i++) spi_bit(1'b0, m);
        cs_high();
        enable = 1'b1;
        repeat (4) @(negedge clk);
        strobe_delta(mask, cnt);
        check("enable_low_regs",   regs, 64'h02015A77C33C3322);
        check("enable_low_pulses", 64'(cnt), 64'h0);

        // Reset mid-transaction restores reset values asynchronously.
        cs_low();
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
        rst_n = 1'b0;
        #1;
        check("midrst_regs", regs, INIT);
        check("midrst_busy", 64'(busy), 64'h0);
        intf.spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_after", regs, INIT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
